wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the single write port of the 32×32 register file. It merges two write-back requesters onto one registered write port (rw/bus_w/reg_wr): port 0 is the single-cycle ALU path and port 1 is the multi-cycle load/mul path. It tracks registers with outstanding slow-path writes and flags read hazards on the two read addresses so the decode stage can stall.

---
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : wb_arbiter
// Brief    : Write-back arbiter and busy-register scoreboard for the single
//            write port of a 32x32 register file. Port 0 (ALU) and port 1
//            (load/mul) share one registered write port; outstanding slow-path
//            destinations are tracked so decode can stall on read hazards.
// Config   : WBARB_STARVE_EN - when defined, a MAX_WAIT starvation counter
//            forces port 1 to win after MAX_WAIT lost cycles; when undefined,
//            port 0 has strict fixed priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic        hazard_a,
  output logic        hazard_b,
  output logic [4:0]  rw,
  output logic [31:0] bus_w,
  output logic        reg_wr
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;
  logic [4:0]  r_rw;
  logic [31:0] r_bus_w;
  logic        r_reg_wr;
  logic        w_req0;
  logic        w_req1;
  logic        w_force1;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_issue_acc;

`ifdef WBARB_STARVE_EN
  logic [3:0]  r_wait_cnt;

  // Port 1 is forced to win once it has lost MAX_WAIT cycles in a row
  assign w_force1 = (r_wait_cnt == c_max_wait);

  // Starvation counter: count port-1 losses, saturate, clear on grant or idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
    end else if (req1_valid && !w_grant1) begin
      if (r_wait_cnt != c_max_wait) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end
`else
  logic        w_unused_cfg;

  // Fixed priority: port 0 always wins when both request
  assign w_force1     = 1'b0;
  assign w_unused_cfg = ^c_max_wait;
`endif

  // Requests are masked while in reset so no ready is ever shown then
  assign w_req0   = req0_valid & ~rst;
  assign w_req1   = req1_valid & ~rst;
  assign w_grant1 = w_req1 & (~w_req0 | w_force1);
  assign w_grant0 = w_req0 & ~w_grant1;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Register 0 never becomes busy, so it is always issuable
  assign issue_ready = ~r_busy[issue_rd] | (issue_rd == 5'd0);
  assign w_issue_acc = issue_valid & issue_ready & (issue_rd != 5'd0);

  // Scoreboard next state: clear on port-1 commit, then set on issue (set wins)
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant1) begin
      w_busy_nxt[req1_rd] = 1'b0;
    end
    if (w_issue_acc) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Registered write port; writes to register 0 are accepted but not enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw     <= 5'd0;
      r_bus_w  <= 32'd0;
      r_reg_wr <= 1'b0;
    end else if (w_grant1) begin
      r_rw     <= req1_rd;
      r_bus_w  <= req1_data;
      r_reg_wr <= (req1_rd != 5'd0);
    end else if (w_grant0) begin
      r_rw     <= req0_rd;
      r_bus_w  <= req0_data;
      r_reg_wr <= (req0_rd != 5'd0);
    end else begin
      r_reg_wr <= 1'b0;
    end
  end

  assign rw     = r_rw;
  assign bus_w  = r_bus_w;
  assign reg_wr = r_reg_wr;

  // Stall on a busy register or on the staged write not yet in the file
  assign hazard_a = (ra != 5'd0) & (r_busy[ra] | (r_reg_wr & (r_rw == ra)));
  assign hazard_b = (rb != 5'd0) & (r_busy[rb] | (r_reg_wr & (r_rw == rb)));

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_arbiter
// Brief    : Directed self-checking bench for wb_arbiter (MAX_WAIT = 4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        hazard_a;
  logic        hazard_b;
  logic [4:0]  rw;
  logic [31:0] bus_w;
  logic        reg_wr;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.MAX_WAIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_rd     (req0_rd),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_rd     (req1_rd),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .ra          (ra),
    .rb          (rb),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .rw          (rw),
    .bus_w       (bus_w),
    .reg_wr      (reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h0;
    req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'h0;
    issue_valid = 1'b0; issue_rd = 5'd3; ra = 5'd5; rb = 5'd6;
    tick();
    total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL rst_reg_wr: got %b want 0", reg_wr); end
    total++; if (rw !== 5'd0) begin bad++; $display("FAIL rst_rw: got %0d want 0", rw); end
    total++; if (bus_w !== 32'd0) begin bad++; $display("FAIL rst_bus_w: got %h want 0", bus_w); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rst_issue_ready: got %b want 1", issue_ready); end
    total++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin bad++; $display("FAIL rst_hazard: got %b%b want 00", hazard_a, hazard_b); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_write;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h1234;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL basic_ready0: got %b want 1", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL basic_ready1: got %b want 0", req1_ready); end
    tick();
    req0_valid = 1'b0; ra = 5'd5;
    #1;
    total++; if (reg_wr !== 1'b1) begin bad++; $display("FAIL basic_reg_wr: got %b want 1", reg_wr); end
    total++; if (rw !== 5'd5) begin bad++; $display("FAIL basic_rw: got %0d want 5", rw); end
    total++; if (bus_w !== 32'h0000_1234) begin bad++; $display("FAIL basic_bus_w: got %h want 00001234", bus_w); end
    total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL basic_staged_hazard: got %b want 1", hazard_a); end
    tick();
    total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL basic_idle_reg_wr: got %b want 0", reg_wr); end
    total++; if (rw !== 5'd5 || bus_w !== 32'h0000_1234) begin bad++; $display("FAIL basic_hold: got rw=%0d bus_w=%h want rw=5 bus_w=00001234", rw, bus_w); end
    total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL basic_hazard_clear: got %b want 0", hazard_a); end
  endtask

  task automatic test_rd0;
    req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hFFFF_FFFF; ra = 5'd0;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rd0_ready0: got %b want 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL rd0_reg_wr: got %b want 0", reg_wr); end
    total++; if (bus_w !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rd0_bus_w: got %h want ffffffff", bus_w); end
    total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL rd0_hazard: got %b want 0", hazard_a); end
    tick();
  endtask

  task automatic test_fairness;
    logic [1:0] exp_rdy;
    logic [4:0] exp_rw;
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'hAAAA_0003;
    req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h7777_0007;
    for (int i = 0; i < 10; i++) begin
`ifdef WBARB_STARVE_EN
      exp_rdy = ((i % 5) == 4) ? 2'b01 : 2'b10;
`else
      exp_rdy = 2'b10;
`endif
      exp_rw = exp_rdy[0] ? 5'd7 : 5'd3;
      #1;
      total++; if ({req0_ready, req1_ready} !== exp_rdy) begin bad++; $display("FAIL fair_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready}, exp_rdy); end
      tick();
      total++; if (rw !== exp_rw || reg_wr !== 1'b1) begin bad++; $display("FAIL fair_write[%0d]: got rw=%0d wr=%b want rw=%0d wr=1", i, rw, reg_wr, exp_rw); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_hazard;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL haz_issue_ready: got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0; ra = 5'd9; rb = 5'd9;
    #1;
    total++; if (hazard_a !== 1'b1 || hazard_b !== 1'b1) begin bad++; $display("FAIL haz_busy: got %b%b want 11", hazard_a, hazard_b); end
    tick();
    // second issue to a busy register is refused and leaves busy set
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL haz_issue_blocked: got %b want 0", issue_ready); end
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL haz_still_busy: got %b want 1", hazard_a); end
    req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h0000_0099;
    #1;
    total++; if (req1_ready !== 1'b1 || hazard_a !== 1'b1) begin bad++; $display("FAIL haz_commit: got rdy=%b haz=%b want rdy=1 haz=1", req1_ready, hazard_a); end
    tick();
    req1_valid = 1'b0;
    #1;
    total++; if (reg_wr !== 1'b1 || rw !== 5'd9 || bus_w !== 32'h0000_0099) begin bad++; $display("FAIL haz_staged_write: got wr=%b rw=%0d data=%h want wr=1 rw=9 data=00000099", reg_wr, rw, bus_w); end
    total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL haz_staged: got %b want 1", hazard_a); end
    tick();
    total++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin bad++; $display("FAIL haz_released: got %b%b want 00", hazard_a, hazard_b); end
  endtask

  task automatic test_set_wins;
    // busy[9] is clear; issue and port-1 commit of rd 9 land on the same edge
    issue_valid = 1'b1; issue_rd = 5'd9;
    req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h0000_0A09;
    ra = 5'd9;
    #1;
    total++; if (issue_ready !== 1'b1 || req1_ready !== 1'b1) begin bad++; $display("FAIL setwin_accept: got issue=%b rdy1=%b want 1 1", issue_ready, req1_ready); end
    tick();
    issue_valid = 1'b0; req1_valid = 1'b0;
    tick();
    total++; if (hazard_a !== 1'b1 || reg_wr !== 1'b0) begin bad++; $display("FAIL setwin_busy: got haz=%b wr=%b want haz=1 wr=0", hazard_a, reg_wr); end
    req1_valid = 1'b1; req1_rd = 5'd9;
    tick();
    req1_valid = 1'b0;
    tick();
    total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL setwin_cleanup: got %b want 0", hazard_a); end
  endtask

  task automatic test_reset_mid;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'h0000_0044;
    tick();
    req0_valid = 1'b0; ra = 5'd12; rb = 5'd4;
    #1;
    total++; if (reg_wr !== 1'b1 || hazard_a !== 1'b1 || hazard_b !== 1'b1) begin bad++; $display("FAIL rmid_pre: got wr=%b haz=%b%b want wr=1 haz=11", reg_wr, hazard_a, hazard_b); end
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; issue_rd = 5'd12;
    #1;
    total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL rmid_reg_wr: got %b want 0", reg_wr); end
    total++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin bad++; $display("FAIL rmid_hazard: got %b%b want 00", hazard_a, hazard_b); end
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready: got %b%b want 00", req0_ready, req1_ready); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rmid_issue_ready: got %b want 1", issue_ready); end
    tick();
    total++; if (reg_wr !== 1'b0 || req0_ready !== 1'b0) begin bad++; $display("FAIL rmid_hold: got wr=%b rdy0=%b want 0 0", reg_wr, req0_ready); end
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    total++; if (reg_wr !== 1'b0 || hazard_a !== 1'b0) begin bad++; $display("FAIL rmid_after: got wr=%b haz=%b want 0 0", reg_wr, hazard_a); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_rd0();
    test_fairness();
    test_hazard();
    test_set_wins();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
